// File: rtl/dct_pkg.sv
// Shared constants, vector types and rounding helpers for the 1-D IDCT lifting datapath.
package dct_pkg;

  localparam int unsigned FRAC_BITS    = 3;
  localparam int unsigned IDCT_IW      = 22;
  localparam int unsigned IDCT_LATENCY = 7;
  localparam int unsigned IDCT_XW      = IDCT_IW + 4;
  localparam int unsigned SAMPLE_W     = 8;
  localparam int unsigned COEF_W       = 16;

  typedef logic signed [IDCT_IW-1:0]  iw_t;
  typedef logic signed [IDCT_XW-1:0]  xw_t;
  typedef iw_t                        iw_vec_t     [8];
  typedef logic signed [SAMPLE_W-1:0] sample_vec_t [8];
  typedef logic signed [COEF_W-1:0]   coef_vec_t   [8];

  // R(v / 2^(sh-3)): v is divided by 2^(sh-3) before rounding to a multiple of 8,
  // ties away from zero; sh = 3 gives plain R(v).
  function automatic iw_t idct_round(input xw_t v, input int unsigned sh);
    xw_t mag;
    xw_t half;
    xw_t q;
    half = xw_t'(1) <<< (sh - 1);
    mag  = (v < 0) ? -v : v;
    q    = (mag + half) >>> sh;
    if (v < 0) q = -q;
    return iw_t'(q <<< FRAC_BITS);
  endfunction

  function automatic xw_t mulk(input iw_t v, input int unsigned k);
    return xw_t'(v) * xw_t'(k);
  endfunction

  function automatic iw_t hsum(input iw_t a, input iw_t b);
    xw_t s;
    s = xw_t'(a) + xw_t'(b);
    return iw_t'(s >>> 1);
  endfunction

  function automatic iw_t hdif(input iw_t a, input iw_t b);
    xw_t s;
    s = xw_t'(a) - xw_t'(b);
    return iw_t'(s >>> 1);
  endfunction

endpackage

// File: rtl/idct_1d_math_if.sv
// Handshake bundle for idct_1d_math: coefficient input stream and sample output stream.
interface idct_1d_math_if #(
  parameter int W  = 8,
  parameter int CW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [CW-1:0] x_in  [8];
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W-1:0]  x_out [8];

  modport master (output in_valid, x_in, out_ready,
                  input  in_ready, out_valid, x_out);
  modport slave  (input  in_valid, x_in, out_ready,
                  output in_ready, out_valid, x_out);
endinterface

// File: rtl/dct_pipe_ctrl.sv
// Valid-bit chain and global stall enable for a DEPTH-stage pipeline with output backpressure.
module dct_pipe_ctrl #(
  parameter int unsigned DEPTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  output logic en,
  output logic in_ready,
  output logic out_valid
);
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  always_comb begin
    en        = ~valid_q[DEPTH-1] | out_ready;
    in_ready  = en;
    out_valid = valid_q[DEPTH-1];
    valid_d   = {valid_q[DEPTH-2:0], in_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/idct_1d_math.sv
// 8-point 1-D IDCT as a lifting pipeline: capture, five lifting/butterfly stages, output stage.
// Build option: define IDCT_SAT_EN to clamp outputs to the W-bit range instead of wrapping.
module idct_1d_math
  import dct_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [CW-1:0] x_in  [8],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W-1:0]  x_out [8]
);
`ifdef IDCT_SAT_EN
  localparam iw_t SMAX = iw_t'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam iw_t SMIN = -SMAX - iw_t'(1);
`endif

  logic    en;
  iw_vec_t c_q, c_d, b1_q, b1_d, b2_q, b2_d;
  iw_vec_t a3_q, a3_d, a4_q, a4_d, a5_q, a5_d;
  logic signed [W-1:0] x_q [8];
  logic signed [W-1:0] x_d [8];

  function automatic logic signed [W-1:0] narrow(input iw_t v);
    iw_t c;
    c = v;
`ifdef IDCT_SAT_EN
    if (v > SMAX) c = SMAX;
    else if (v < SMIN) c = SMIN;
`endif
    return c[W-1:0];
  endfunction

  dct_pipe_ctrl #(.DEPTH(IDCT_LATENCY)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .en        (en),
    .in_ready  (in_ready),
    .out_valid (out_valid)
  );

  always_comb begin
    iw_t s;
    iw_t d;
    s = '0;
    d = '0;
    for (int unsigned i = 0; i < 8; i++) c_d[i] = iw_t'(x_in[i]) <<< FRAC_BITS;

    b1_d    = c_q;
    b1_d[1] = idct_round(xw_t'(c_q[0]), 4) - c_q[1];
    b1_d[3] = c_q[3] - idct_round(mulk(c_q[2], 3), 6);
    b1_d[4] = c_q[4] + idct_round(xw_t'(c_q[7]), 6);
    b1_d[6] = c_q[6] + idct_round(xw_t'(c_q[5]), 4);

    b2_d    = b1_q;
    b2_d[0] = b1_q[0] - b1_q[1];
    b2_d[2] = b1_q[2] + idct_round(mulk(b1_q[3], 3), 6);
    b2_d[5] = b1_q[5] - idct_round(mulk(b1_q[6], 7), 6);

    a3_d[0] = hsum(b2_q[0], b2_q[3]);
    a3_d[3] = hdif(b2_q[0], b2_q[3]);
    a3_d[1] = hsum(b2_q[1], b2_q[2]);
    a3_d[2] = hdif(b2_q[1], b2_q[2]);
    a3_d[4] = hsum(b2_q[4], b2_q[5]);
    a3_d[5] = hdif(b2_q[4], b2_q[5]);
    a3_d[7] = hsum(b2_q[7], b2_q[6]);
    a3_d[6] = hdif(b2_q[7], b2_q[6]);

    a4_d    = a3_q;
    a4_d[5] = idct_round(mulk(a3_q[6], 5), 6) - a3_q[5];

    a5_d    = a4_q;
    a5_d[6] = a4_q[6] - idct_round(mulk(a4_q[5], 3), 6);

    for (int unsigned i = 0; i < 8; i++) x_d[i] = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      s          = hsum(a5_q[i], a5_q[7-i]);
      d          = hdif(a5_q[i], a5_q[7-i]);
      x_d[i]     = narrow(idct_round(xw_t'(s), 3) >>> FRAC_BITS);
      x_d[7-i]   = narrow(idct_round(xw_t'(d), 3) >>> FRAC_BITS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q  <= '{default: '0};
      b1_q <= '{default: '0};
      b2_q <= '{default: '0};
      a3_q <= '{default: '0};
      a4_q <= '{default: '0};
      a5_q <= '{default: '0};
      x_q  <= '{default: '0};
    end else if (en) begin
      c_q  <= c_d;
      b1_q <= b1_d;
      b2_q <= b2_d;
      a3_q <= a3_d;
      a4_q <= a4_d;
      a5_q <= a5_d;
      x_q  <= x_d;
    end
  end

  assign x_out = x_q;
endmodule

// File: tb/tb_idct_1d_math.sv
// Scoreboard bench for idct_1d_math: directed vectors, stalls, streaming and mid-stream reset.
module tb_idct_1d_math;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  idct_1d_math_if #(.W(8), .CW(16)) bus ();

  idct_1d_math #(.W(8), .CW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .x_in      (bus.x_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .x_out     (bus.x_out)
  );

  int errors = 0;
  int checks = 0;
  int exp_q [$];
  int vin  [8][8];
  int vexp [8][8];
  int mon_k;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [63:0] got_vec();
    logic [63:0] p;
    for (int j = 0; j < 8; j++) p[j*8 +: 8] = bus.x_out[j];
    return p;
  endfunction

  function automatic logic [63:0] want_vec(input int k);
    logic [63:0] p;
    for (int j = 0; j < 8; j++) p[j*8 +: 8] = 8'(vexp[k][j]);
    return p;
  endfunction

  // Monitor: every output handshake pops the oldest accepted vector.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_k = exp_q.pop_front();
        chk("out_vec", got_vec(), want_vec(mon_k));
      end
    end
  end

  task automatic drive_vec(input int k);
    for (int j = 0; j < 8; j++) bus.x_in[j] = 16'(vin[k][j]);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int k);
    bit acc;
    acc = 1'b0;
    drive_vec(k);
    bus.in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        exp_q.push_back(k);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic send_lat(input int k);
    int n;
    send(k);
    bus.in_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.out_valid === 1'b1) break;
    end
    chk("latency", 64'(n), 64'd7);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  pat;
    int          nv;
    vin[0] = '{64, 0, 0, 0, 0, 0, 0, 0};     vexp[0] = '{8, 8, 8, 8, 8, 8, 8, 8};
    vin[1] = '{0, 64, 0, 0, 0, 0, 0, 0};     vexp[1] = '{16, -16, -16, 16, 16, -16, -16, 16};
    vin[2] = '{0, 0, 0, 0, 0, 0, 0, 64};     vexp[2] = '{16, 13, 8, 2, -2, -8, -13, -16};
    vin[3] = '{4, 0, 0, 0, 0, 0, 0, 0};      vexp[3] = '{1, 1, 1, 1, 1, 1, 1, 1};
    vin[4] = '{-4, 0, 0, 0, 0, 0, 0, 0};     vexp[4] = '{-1, -1, -1, -1, -1, -1, -1, -1};
    vin[5] = '{-64, 0, 0, 0, 0, 0, 0, 0};    vexp[5] = '{-8, -8, -8, -8, -8, -8, -8, -8};
    vin[6] = '{64, 64, 0, 0, 0, 0, 0, 0};    vexp[6] = '{24, -8, -8, 24, 24, -8, -8, 24};
    vin[7] = '{32767, 0, 0, 0, 0, 0, 0, 0};
`ifdef IDCT_SAT_EN
    vexp[7] = '{127, 127, 127, 127, 127, 127, 127, 127};
`else
    vexp[7] = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

    // Reset held for two edges with a valid input pending
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive_vec(0);
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_x_out", got_vec(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Single vectors with latency measurement
    send_lat(0);
    for (int k = 3; k < 8; k++) send_lat(k);

    // Back-to-back stream of four vectors
    for (int k = 0; k < 4; k++) send(k);
    bus.in_valid = 1'b0;
    pat = '0;
    repeat (10) begin
      @(negedge clk);
      pat = {pat[8:0], bus.out_valid};
    end
    chk("stream_pattern", 64'(pat), 64'(10'b0001111000));
    @(posedge clk); #1;

    // Fill the pipe under backpressure, then release
    bus.out_ready = 1'b0;
    for (int k = 0; k < 7; k++) send(k);
    drive_vec(7);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    repeat (3) @(negedge clk);
    chk("bp_hold", got_vec(), want_vec(0));
    chk("bp_in_ready_held", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset with three vectors in flight
    for (int k = 0; k < 3; k++) send(k);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) nv++;
    end
    chk("rst_no_stale", 64'(nv), 64'd0);
    @(posedge clk); #1;
    send_lat(1);
    send_lat(2);
    send_lat(6);

    repeat (5) @(posedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
